// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO result registers: multi-cycle mult/multu, radix-2 restoring div/divu, mthi/mtlo.
// Optional macro MDU_DIVZERO_EN adds a divzero flag and a single-cycle divide-by-zero completion.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MDU_DIVZERO_EN
  ,
  output logic        divzero
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MDU_DIVZERO_EN
  logic        dz_q, dz_d;
  logic        divzero_q, divzero_d;
`endif

  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] dvs;
  logic [32:0] sub;

  // Sign-extending to 64 bits lets one truncated multiply serve both signed and unsigned.
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  assign dvs = (sgn_q && b_q[31]) ? -b_q : b_q;
  // Partial remainder never exceeds the divisor magnitude, so bit 32 of the difference is the borrow.
  assign sub = {rem_q, quo_q[31]} - {1'b0, dvs};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIVZERO_EN
    dz_d      = dz_q;
    divzero_d = divzero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = ~op[0];
              cnt_d   = 5'(MUL_CYCLES - 1);
              state_d = MUL;
`ifdef MDU_DIVZERO_EN
              divzero_d = 1'b0;
`endif
            end
            3'b010, 3'b011: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = ~op[0];
              rem_d   = '0;
              quo_d   = (!op[0] && a[31]) ? -a : a;
              cnt_d   = 5'd31;
              state_d = DIV;
`ifdef MDU_DIVZERO_EN
              divzero_d = 1'b0;
              dz_d      = (b == 32'd0);
              if (b == 32'd0) state_d = FIX;
`endif
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == 5'd0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        rem_d = sub[32] ? {rem_q[30:0], quo_q[31]} : sub[31:0];
        quo_d = {quo_q[30:0], ~sub[32]};
        if (cnt_q == 5'd0) state_d = FIX;
        else cnt_d = cnt_q - 5'd1;
      end
      FIX: begin
        hi_d    = (sgn_q && a_q[31]) ? -rem_q : rem_q;
        lo_d    = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
        state_d = DONE;
`ifdef MDU_DIVZERO_EN
        if (dz_q) begin
          hi_d      = a_q;
          lo_d      = 32'hFFFF_FFFF;
          divzero_d = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIVZERO_EN
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIVZERO_EN
      dz_q      <= dz_d;
      divzero_q <= divzero_d;
`endif
    end
  end

  assign busy = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIVZERO_EN
  assign divzero = divzero_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mult/div results, busy/done timing, mthi/mtlo, reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIVZERO_EN
  logic        divzero;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIVZERO_EN
    , .divzero(divzero)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, check n busy cycles with HI/LO frozen, then the done cycle and the return to idle.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                     input int n, input logic [31:0] ehi, input logic [31:0] elo);
    op = o; a = va; b = vb; start = 1'b1;
    step();
    start = 1'b0; op = 3'b001; a = ~va; b = vb + 32'd1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
      chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      // A start during busy must be ignored, including an mthi.
      start = (i == 1);
      op    = (i == 1) ? 3'b100 : 3'b001;
      a     = 32'hDEAD_BEEF;
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    m_hi = ehi; m_lo = elo;
    step();
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    step();
    step();
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
`ifdef MDU_DIVZERO_EN
    chk("rst_divzero", {63'd0, divzero}, 64'd0);
`endif
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    step();

    run("mult",      3'b000, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run("div",       3'b010, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",      3'b011, 32'hFFFF_FFF9, 32'd2,         33, 32'h0000_0001, 32'h7FFF_FFFC);
    run("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
    run("div_negb",  3'b010, 32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    run("divu_small",3'b011, 32'd3,         32'd10,        33, 32'h0000_0003, 32'h0000_0000);

    // mthi then mtlo on consecutive edges
    op = 3'b100; a = 32'h1234_5678; start = 1'b1;
    step();
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("mthi_flags", {62'd0, busy, done}, 64'd0);
    op = 3'b101; a = 32'h9ABC_DEF0;
    step();
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    chk("mtlo_flags", {62'd0, busy, done}, 64'd0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // Reserved op is ignored
    op = 3'b110; a = 32'h5555_5555; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    chk("rsvd_flags", {62'd0, busy, done}, 64'd0);
    step();
    chk("rsvd_flags2", {62'd0, busy, done}, 64'd0);
    chk("rsvd_hilo", {hi, lo}, {m_hi, m_lo});

`ifdef MDU_DIVZERO_EN
    run("divzero", 3'b010, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
    chk("divzero_set", {63'd0, divzero}, 64'd1);
    run("mult_clr", 3'b000, 32'd2, 32'd3, 5, 32'd0, 32'd6);
    chk("divzero_clr", {63'd0, divzero}, 64'd0);
`endif

    // divu aborted by reset at busy cycle 10; a simultaneous start is ignored
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("abort_busy10", {62'd0, busy, done}, 64'd2);
    rst = 1'b1; start = 1'b1; op = 3'b100; a = 32'h0000_0055;
    step();
    rst = 1'b0; start = 1'b0;
    chk("abort_flags", {62'd0, busy, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    step();
    chk("abort_flags2", {62'd0, busy, done}, 64'd0);
    chk("abort_hilo2", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5: busy cycles for mult/multu, legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle command strobe from the controller.
REQ-005 SHALL have port op, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 reserved.
REQ-006 SHALL have port a, input, 32 bits: rs operand (dividend, multiplicand, or mthi/mtlo data).
REQ-007 SHALL have port b, input, 32 bits: rt operand (divisor or multiplier).
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress and the controller must stall any mult/div/mf/mt.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO take a new mult/div result.
REQ-010 SHALL have port hi, output, 32 bits: HI register.
REQ-011 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV, FIX and DONE.
REQ-013 SHALL sample start only in IDLE; start while busy=1 or with a reserved op SHALL be ignored with no state change.
REQ-014 SHALL perform mthi/mtlo (start in IDLE) by writing a into hi/lo at that edge, with no busy and no done.
REQ-015 SHALL, on mult/multu, latch a and b and go IDLE->MUL, hold busy=1 for exactly MUL_CYCLES cycles, then go to DONE.
REQ-016 SHALL form the 64-bit product as signed for mult and unsigned for multu: {hi,lo}=product.
REQ-017 SHALL, on div/divu, go IDLE->DIV, run 32 radix-2 restoring iterations on operand magnitudes (32 cycles), spend 1 cycle in FIX for sign correction, then go to DONE; busy=1 for 33 cycles.
REQ-018 SHALL produce lo=quotient and hi=remainder; signed div truncates toward zero and the remainder takes the dividend's sign.
REQ-019 SHALL give 0x80000000 div 0xFFFFFFFF the result lo=0x80000000, hi=0.
REQ-020 SHALL, in DONE, have busy=0, done=1, and hi/lo showing the new result, then return to IDLE next cycle; done SHALL be asserted in no other state.
REQ-021 SHALL hold hi/lo at their previous values throughout MUL/DIV/FIX, using internal working registers only.
REQ-022 SHALL accept a new start in the cycle after DONE (back-to-back).
REQ-023 SHALL latch operands at start so that changes to a/b/op during busy have no effect.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set state=IDLE, busy=0, done=0, hi=0, lo=0 and clear working registers.
REQ-025 SHALL let reset abort any operation mid-flight, with no result written.
REQ-026 SHALL ignore start when rst=1 in the same cycle.

Configuration
REQ-027 SHALL provide macro MDU_DIVZERO_EN.
REQ-028 SHALL, when MDU_DIVZERO_EN is defined, add output divzero (1 bit), reset value 0.
REQ-029 SHALL, when MDU_DIVZERO_EN is defined, complete div/divu with b=0 in 1 busy cycle: hi=a, lo=0xFFFFFFFF, done pulse, divzero=1 until the next accepted mult/div start or reset.
REQ-030 SHALL, when MDU_DIVZERO_EN is undefined, have no divzero port and run b=0 through the normal 33-cycle path with hi/lo contents unspecified.

Verification
REQ-031 SHALL cover: mult a=0xFFFFFFFE (-2), b=3, MUL_CYCLES=5 -> busy for 5 cycles, then done with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL cover: multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL cover: div a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-034 SHALL cover: mthi 0x12345678, then mtlo 0x9ABCDEF0 in consecutive cycles -> hi/lo updated one edge after each, busy never set.
REQ-035 SHALL cover: divu started, rst pulsed at busy cycle 10 -> next cycle busy=0, hi=lo=0, no done; start ignored during busy.
REQ-036 SHALL cover, with MDU_DIVZERO_EN: div a=5, b=0 -> done two cycles after start, hi=5, lo=0xFFFFFFFF, divzero=1.
